// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the 5-stage pipeline.
//   regbits_t    : register index
//   word_t       : datapath word
//   ctrl_state_t : sequencing state of pipeline_ctrl
//   ctrl_out_t   : bundle of latch enables / flushes produced each cycle
package cpu_types_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } ctrl_out_t;

    // r0 is hardwired to zero, so a load targeting it never creates a hazard.
    function automatic logic load_use_hazard(input logic     ex_memread,
                                             input regbits_t ex_rd,
                                             input regbits_t id_rs,
                                             input regbits_t id_rt);
        return ex_memread && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance statistics.
//   CLK   : clock, rising edge
//   nRST  : synchronous active-low reset, clears the count
//   inc   : add one this cycle (ignored once the count is all-ones)
//   count : current value
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Produces per-cycle PC / pipeline-latch enables and bubble-insert flushes
// from cache handshakes, load-use hazards, redirects and halt.
//   CLK, nRST                       : clock / synchronous active-low reset
//   ihit, dhit                      : icache / dcache completion
//   mem_dren, mem_dwen              : MEM-stage dmem read / write request
//   mem_branch_taken, mem_halt      : MEM-stage redirect / halt
//   id_jump, id_rs, id_rt           : ID-stage jump and source registers
//   ex_memread, ex_rd               : EX-stage load and destination register
//   pc_en, *_en                     : PC and latch enables
//   ifid/idex/exmem_flush           : insert bubble on next edge
//   halted                          : sticky halt indication
//   stall_cnt, flush_cnt            : saturating performance counters
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dren,
    input  logic             mem_dwen,
    input  logic             mem_branch_taken,
    input  logic             mem_halt,
    input  logic             id_jump,
    input  regbits_t         id_rs,
    input  regbits_t         id_rt,
    input  logic             ex_memread,
    input  regbits_t         ex_rd,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_t state, state_nxt;
    ctrl_out_t   co;
    logic        dmem_pend;
    logic        stall_inc, flush_inc;

    assign dmem_pend = (mem_dren | mem_dwen) & ~dhit;

    always_comb begin
        co        = '0;
        state_nxt = state;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state)
            // The cycle DWAIT sees its access complete is an ordinary RUN
            // cycle: the whole pipe advances and every RUN rule applies,
            // including a redirect or halt that was waiting behind the miss.
            RUN, DWAIT: begin
                if (dmem_pend) begin
                    state_nxt = DWAIT;
                end else begin
                    state_nxt = RUN;
                    if (mem_halt) begin
                        // Retire everything up to MEM, squash the younger ones.
                        co.memwb_en    = 1'b1;
                        co.ifid_flush  = 1'b1;
                        co.idex_flush  = 1'b1;
                        co.exmem_flush = 1'b1;
                        state_nxt      = DRAIN;
                    end else if (mem_branch_taken) begin
                        co             = '1;
                        flush_inc      = 1'b1;
                    end else if (load_use_hazard(ex_memread, ex_rd, id_rs, id_rt)) begin
                        // Hold PC and IF/ID, bubble into EX, let older ones go.
                        co.idex_flush  = 1'b1;
                        co.exmem_en    = 1'b1;
                        co.memwb_en    = 1'b1;
                        stall_inc      = 1'b1;
                    end else if (id_jump && ihit) begin
                        co             = '1;
                        co.idex_flush  = 1'b0;
                        co.exmem_flush = 1'b0;
                        flush_inc      = 1'b1;
                    end else if (!ihit) begin
                        co.ifid_flush  = 1'b1;
                        co.idex_en     = 1'b1;
                        co.exmem_en    = 1'b1;
                        co.memwb_en    = 1'b1;
                    end else begin
                        co.pc_en       = 1'b1;
                        co.ifid_en     = 1'b1;
                        co.idex_en     = 1'b1;
                        co.exmem_en    = 1'b1;
                        co.memwb_en    = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // One cycle to write back the instruction ahead of the halt.
                co.memwb_en = 1'b1;
                state_nxt   = HALTED;
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if (!nRST) begin
            co        = '0;
            stall_inc = 1'b0;
            flush_inc = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    assign pc_en       = co.pc_en;
    assign ifid_en     = co.ifid_en;
    assign idex_en     = co.idex_en;
    assign exmem_en    = co.exmem_en;
    assign memwb_en    = co.memwb_en;
    assign ifid_flush  = co.ifid_flush;
    assign idex_flush  = co.idex_flush;
    assign exmem_flush = co.exmem_flush;
    assign halted      = (state == HALTED);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Generates per-cycle enable/flush for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches from cache hits, load-use hazards, branch/jump redirects and halt.
- Runs a small FSM for dmem freezes and the halt drain, and keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 16, width of the performance counters (saturating).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  synchronous active-low reset, sampled on CLK rising edge.
- ihit  in  1  icache returned the instruction this cycle.
- dhit  in  1  dcache completed the MEM-stage access this cycle.
- mem_dren  in  1  MEM-stage instruction reads dmem.
- mem_dwen  in  1  MEM-stage instruction writes dmem.
- mem_branch_taken  in  1  branch resolved taken in MEM.
- mem_halt  in  1  halt opcode in MEM.
- id_jump  in  1  J/JAL/JR decoded in ID.
- id_rs  in  5  ID source register (regbits_t).
- id_rt  in  5  ID source register (regbits_t).
- ex_memread  in  1  EX-stage instruction is a load.
- ex_rd  in  5  EX-stage destination register (regbits_t).
- pc_en  out  1  PC may update.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  insert bubble on next edge.
- halted  out  1  processor halted, sticky until reset.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  redirect flush events.

Behaviour:
- Reset (nRST=0 at edge): state←RUN; counters←0; halted←0. While nRST=0, all enables and flushes are forced to 0 combinationally.
- The FSM is registered. Enables and flushes are combinational from state and inputs, with zero latency.
- States:
  - RUN: normal operation.
  - DWAIT: entered when (mem_dren|mem_dwen)&!dhit in RUN. Stays in DWAIT until dhit, then returns to RUN.
  - DRAIN: entered from RUN when mem_halt and not freezing. Lasts exactly 1 cycle, then goes to HALTED.
  - HALTED: absorbing until reset.
- Freeze: `dmem_pend = (mem_dren|mem_dwen)&!dhit`. When dmem_pend is true in RUN or DWAIT, all enables=0 and all flushes=0; nothing else is evaluated.
- Otherwise, in RUN, the following rules apply in priority order (first match wins):
  1. mem_halt: pc_en=0; ifid_flush=idex_flush=exmem_flush=1; memwb_en=1.
  2. mem_branch_taken: all enables=1; ifid_flush=idex_flush=exmem_flush=1; flush_cnt+1.
  3. Load-use, defined as `ex_memread & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt)`: pc_en=0; ifid_en=0; idex_flush=1; exmem_en=memwb_en=1; stall_cnt+1.
  4. id_jump & ihit: all enables=1; ifid_flush=1; flush_cnt+1.
  5. !ihit: pc_en=0; ifid_flush=1; downstream enables=1.
  6. Default: all enables=1, no flush.
- DRAIN: pc_en=0; memwb_en=1; all other enables=0; all flushes=0.
- HALTED: all enables=0; halted=1.
- Flush overrides enable for the same latch.
- Register 0 never causes a load-use hazard.
- Counters saturate at all-ones and never wrap.
- A reset asserted mid-DWAIT or mid-DRAIN returns to RUN on that edge, and outputs are 0 that cycle.
- dhit with no pending access is ignored.

Decomposition:
- ctrl_state_t enum {RUN, DWAIT, DRAIN, HALTED} goes in cpu_types_pkg; regbits_t and word_t are already there.
- One natural sub-module: sat_counter (CNT_W, inc, CLK, nRST), instantiated twice.

Test Plan:
- Reset: hold nRST=0 for 2 cycles with ihit=1 -> all enables/flushes=0, stall_cnt=flush_cnt=0, halted=0. After release with ihit=1 -> all enables=1.
- Load-use: ex_memread=1, ex_rd=5, id_rs=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1, stall_cnt 0→1. Repeat with ex_rd=0 -> no stall.
- Dmem freeze: mem_dren=1, dhit=0 for 3 cycles then dhit=1 -> state DWAIT, all enables=0 for 3 cycles; hit cycle enables=1; RUN after.
- Branch vs jump: mem_branch_taken=1 and id_jump=1 together -> 3 flushes asserted, flush_cnt+1 only once.
- Halt: mem_halt=1 -> DRAIN for 1 cycle with memwb_en=1 only, then halted=1 permanently despite ihit/branch activity; nRST=0 clears it.
- Saturation: CNT_W=2, 5 consecutive load-use cycles -> stall_cnt reaches 3 and stays 3.
